alm_mac_accumulator: RTL
========================

Name: alm_mac_accumulator

Overview:
- Downstream consumer of the 8-bit approximate log multiplier's 17-bit sign/one's-complement product.
- Converts each product to two's complement and accumulates a frame of products into a signed ACC_W-bit sum. Frames are delimited by last_i.
- Presents the final sum on a valid/ready output port. Forms the MAC tail of the approximate dot-product datapath.

Parameters:
- PROD_W, 17, product width; bit PROD_W-1 is the sign, bits PROD_W-2:0 are the magnitude XOR {sign}.
- ACC_W, 24, accumulator and output width, signed two's complement; must be >= PROD_W+1.
- LEN_W, 8, width of the per-frame product counter.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- prod_valid_i  input  1  product valid.
- prod_ready_o  output  1  block can accept a product.
- prod_i  input  PROD_W  product; bit 16 = sign, bits 15:0 = magnitude XOR {16{sign}}.
- last_i  input  1  qualifies prod_i as the final product of the frame.
- clear_i  input  1  synchronous frame abort.
- acc_valid_o  output  1  frame sum valid.
- acc_ready_i  input  1  consumer takes the sum.
- acc_o  output  ACC_W  frame sum, signed.
- count_o  output  LEN_W  products accepted in the current frame.
- overflow_o  output  1  sticky signed-overflow flag for the current frame.

Behaviour:
- Reset: state=ACCUM, partial sum=0, acc_o=0, acc_valid_o=0, count_o=0, overflow_o=0, prod_ready_o=1. Reset takes effect immediately, including mid-frame and mid-HOLD; the partial frame is lost.
- Conversion: signed value = sext_ACC_W({prod_i[16], prod_i[15:0]}) + prod_i[16].
  - Example: 17'h1FFCD -> -50.
  - Negative zero 17'h1FFFF -> 0.
- The accept handshake is prod_valid_i & prod_ready_o.
- State machine, two states:
  - ACCUM: prod_ready_o=1, acc_valid_o=0.
    - On accept: sum <= sum + value; count <= count+1, saturating at all-ones; overflow_o is set if the signed add overflows.
    - If last_i is high on accept: acc_o <= new sum, acc_valid_o <= 1, state <= HOLD.
    - Latency: the sum is visible on the cycle after the last accept.
  - HOLD: prod_ready_o=0; prod_valid_i is ignored; acc_o, count_o and overflow_o are held stable.
    - On acc_ready_i=1: acc_valid_o <= 0; sum, count and overflow <= 0; state <= ACCUM. The next product can be accepted on the following cycle.
- Single-product frame (first accept carries last_i): acc_o = value, count_o=1.
- clear_i has priority over everything except reset.
  - Sum, count and overflow <= 0; acc_valid_o <= 0; state <= ACCUM.
  - A product handshaking in the same cycle is discarded.
  - In HOLD, a pending unread sum is dropped.
- acc_ready_i while acc_valid_o=0 has no effect.
- All outputs are registered, or decoded directly from the state register. There are no combinational input-to-output paths.

Optional Feature:
- Macro: ALM_ACC_SAT_EN.
- Defined: on signed overflow the sum clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) and stays clamped unless later adds bring it back in range; overflow_o is still set.
- Undefined: the sum wraps modulo 2^ACC_W; overflow_o is set.

Test Plan:
- Reset mid-frame: after accepting 100 and 200, assert rst_i asynchronously -> acc_o=0, count_o=0, acc_valid_o=0, prod_ready_o=1 immediately; the next frame 7 (last) gives acc_o=7.
- Positive frame: 17'h00064, 17'h000C8, 17'h0012C (last) -> one cycle later acc_valid_o=1, acc_o=24'h000258 (600), count_o=3, overflow_o=0.
- Negative and negative-zero: 17'h1FFCD, 17'h1FFFF, 17'h00014 (last) -> acc_o=24'hFFFFE2 (-30), count_o=3.
- Backpressure: hold acc_ready_i=0 for 5 cycles after the sum appears, driving prod_valid_i=1 with 17'h00009 -> prod_ready_o=0 and acc_o stable throughout; then acc_ready_i=1 -> acc_valid_o=0, and a new frame 9 (last) gives acc_o=9.
- Clear: accept 50, then clear_i together with a valid product 20 -> count_o=0 and the product is dropped; frame 3 (last) gives acc_o=3.
- Overflow with ACC_W=18: inputs 17'h0FFFF, 17'h0FFFF, 17'h00002 (last).
  - Without the macro: acc_o=18'h20000, overflow_o=1.
  - With ALM_ACC_SAT_EN: acc_o=18'h1FFFF, overflow_o=1.

Source files
------------

// File: rtl/alm_mac_accumulator_if.sv
// Product/sum handshake bundle for the approximate-multiplier MAC tail.
// Master drives products and takes sums; slave is the accumulator.
interface alm_mac_accumulator_if #(
    parameter int PROD_W = 17,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
);
    logic              prod_valid_i;
    logic              prod_ready_o;
    logic [PROD_W-1:0] prod_i;
    logic              last_i;
    logic              clear_i;
    logic              acc_valid_o;
    logic              acc_ready_i;
    logic [ACC_W-1:0]  acc_o;
    logic [LEN_W-1:0]  count_o;
    logic              overflow_o;

    modport master (
        output prod_valid_i,
        output prod_i,
        output last_i,
        output clear_i,
        output acc_ready_i,
        input  prod_ready_o,
        input  acc_valid_o,
        input  acc_o,
        input  count_o,
        input  overflow_o
    );

    modport slave (
        input  prod_valid_i,
        input  prod_i,
        input  last_i,
        input  clear_i,
        input  acc_ready_i,
        output prod_ready_o,
        output acc_valid_o,
        output acc_o,
        output count_o,
        output overflow_o
    );
endinterface

// File: rtl/alm_mac_accumulator.sv
// Frame accumulator for sign/one's-complement log-multiplier products.
// Define ALM_ACC_SAT_EN to clamp on signed overflow instead of wrapping.
module alm_mac_accumulator #(
    parameter int PROD_W = 17,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    alm_mac_accumulator_if.slave bus
);
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   sum_q;
    logic [ACC_W-1:0]   acc_q;
    logic [LEN_W-1:0]   cnt_q;
    logic               ovf_q;
    logic               vld_q;

    logic               sign;
    logic [ACC_W-1:0]   value;
    logic [ACC_W:0]     sum_ext;
    logic               add_ovf;
    logic [ACC_W-1:0]   sum_nxt;
    logic               accept;

    assign accept = bus.prod_valid_i && (state == ACCUM);

    // Convert to two's complement and form the overflow-checked sum
    always_comb begin
        sign    = bus.prod_i[PROD_W-1];
        value   = {{(ACC_W-PROD_W){sign}}, bus.prod_i}
                + {{(ACC_W-1){1'b0}}, sign};
        sum_ext = {sum_q[ACC_W-1], sum_q}
                + {value[ACC_W-1], value};
        add_ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
        sum_nxt = sum_ext[ACC_W-1:0];
`ifdef ALM_ACC_SAT_EN
        if (add_ovf) begin
            if (sum_ext[ACC_W])
                sum_nxt = {1'b1, {(ACC_W-1){1'b0}}};
            else
                sum_nxt = {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
    end

    // Frame state machine with registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ACCUM;
            sum_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            vld_q <= 1'b0;
        end else if (bus.clear_i) begin
            state <= ACCUM;
            sum_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        sum_q <= sum_nxt;
                        if (cnt_q != '1)
                            cnt_q <= cnt_q + 1'b1;
                        if (add_ovf)
                            ovf_q <= 1'b1;
                        if (bus.last_i) begin
                            acc_q <= sum_nxt;
                            vld_q <= 1'b1;
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.acc_ready_i) begin
                        vld_q <= 1'b0;
                        sum_q <= '0;
                        cnt_q <= '0;
                        ovf_q <= 1'b0;
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.prod_ready_o = (state == ACCUM);
    assign bus.acc_valid_o  = vld_q;
    assign bus.acc_o        = acc_q;
    assign bus.count_o      = cnt_q;
    assign bus.overflow_o   = ovf_q;
endmodule
